// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and forwarding control for the five-stage
// MIPS pipeline. A shadow pipeline (E, M, W) mirrors the register-write and
// load flags of the instructions downstream of decode. Every hazard output is
// derived combinationally from that shadow state and the decode fields.
// Saturating stall/flush counters are provided for performance debug.
//
// Handshake: none. D fields are sampled on every rising edge. When stall is
// high the upstream F/D register is expected to hold, so the same D fields
// are presented again in the following cycle.
module hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs_id5,
    input  logic [4:0]       rt_id5,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             branch_id,
    input  logic             zero_id,
    input  logic             wreg_id,
    input  logic             load_id,
    input  logic [4:0]       dst_id5,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             forward_rd1_od,
    output logic             forward_rd2_od,
    output logic [1:0]       forward_a_oe2,
    output logic [1:0]       forward_b_oe2,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // A register read matches a slot only if it is not $0 and the slot holds
    // a valid instruction that writes that register.
    function automatic logic f_match(input logic [4:0] x, input logic v,
                                     input logic wr, input logic [4:0] dst);
        return (x != 5'd0) && v && wr && (dst == x);
    endfunction

    // D slot state
    logic             r_d_bubble;

    // E slot: source fields are kept because EX forwarding is based on them
    logic             r_e_valid;
    logic             r_e_wreg;
    logic             r_e_load;
    logic [4:0]       r_e_dst;
    logic [4:0]       r_e_rs;
    logic [4:0]       r_e_rt;

    // M slot: only the producer-side fields are consumed downstream
    logic             r_m_valid;
    logic             r_m_wreg;
    logic             r_m_load;
    logic [4:0]       r_m_dst;

    // W slot: a load's data arrives via WB, so the load flag is not needed here
    logic             r_w_valid;
    logic             r_w_wreg;
    logic [4:0]       r_w_dst;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_dv;
    logic             w_rs_e;
    logic             w_rt_e;
    logic             w_rs_m;
    logic             w_rt_m;
    logic             w_lwstall;
    logic             w_brstall;
    logic             w_stall;
    logic             w_flush_d;
    logic             w_ea_m;
    logic             w_ea_w;
    logic             w_eb_m;
    logic             w_eb_w;

    assign w_dv   = ~r_d_bubble;

    assign w_rs_e = f_match(rs_id5, r_e_valid, r_e_wreg, r_e_dst);
    assign w_rt_e = f_match(rt_id5, r_e_valid, r_e_wreg, r_e_dst);
    assign w_rs_m = f_match(rs_id5, r_m_valid, r_m_wreg, r_m_dst);
    assign w_rt_m = f_match(rt_id5, r_m_valid, r_m_wreg, r_m_dst);

    // Load in E feeding the instruction in D: one bubble before WB can forward
    assign w_lwstall = w_dv & r_e_load & ((uses_rs_id & w_rs_e) | (uses_rt_id & w_rt_e));

    // The decode comparator needs operands now: wait for E producers and for
    // loads still in M (their data is not available until WB)
    assign w_brstall = w_dv & branch_id &
                       (w_rs_e | w_rt_e | (w_rs_m & r_m_load) | (w_rt_m & r_m_load));

    assign w_stall   = w_lwstall | w_brstall;
    // A stalled branch must not flush; it re-evaluates after the stall clears
    assign w_flush_d = w_dv & branch_id & zero_id & ~w_stall;

    assign stall_f_o = w_stall;
    assign stall_d_o = w_stall;
    assign flush_e_o = w_stall;
    assign flush_d_o = w_flush_d;

    // Decode-stage forwarding only from a non-load ALU result in MEM
    assign forward_rd1_od = w_dv & w_rs_m & ~r_m_load;
    assign forward_rd2_od = w_dv & w_rt_m & ~r_m_load;

    assign w_ea_m = f_match(r_e_rs, r_m_valid, r_m_wreg, r_m_dst) & ~r_m_load;
    assign w_ea_w = f_match(r_e_rs, r_w_valid, r_w_wreg, r_w_dst);
    assign w_eb_m = f_match(r_e_rt, r_m_valid, r_m_wreg, r_m_dst) & ~r_m_load;
    assign w_eb_w = f_match(r_e_rt, r_w_valid, r_w_wreg, r_w_dst);

    // EX operand selects: MEM (youngest) wins over WB
    assign forward_a_oe2 = w_ea_m ? 2'b10 : (w_ea_w ? 2'b01 : 2'b00);
    assign forward_b_oe2 = w_eb_m ? 2'b10 : (w_eb_w ? 2'b01 : 2'b00);

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    // Advance the shadow pipeline; a stall or masked D slot injects a bubble into E
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d_bubble <= 1'b1;
            r_e_valid  <= 1'b0;
            r_e_wreg   <= 1'b0;
            r_e_load   <= 1'b0;
            r_e_dst    <= 5'd0;
            r_e_rs     <= 5'd0;
            r_e_rt     <= 5'd0;
            r_m_valid  <= 1'b0;
            r_m_wreg   <= 1'b0;
            r_m_load   <= 1'b0;
            r_m_dst    <= 5'd0;
            r_w_valid  <= 1'b0;
            r_w_wreg   <= 1'b0;
            r_w_dst    <= 5'd0;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_wreg  <= r_m_wreg;
            r_w_dst   <= r_m_dst;

            r_m_valid <= r_e_valid;
            r_m_wreg  <= r_e_wreg;
            r_m_load  <= r_e_load;
            r_m_dst   <= r_e_dst;

            r_e_dst   <= dst_id5;
            r_e_rs    <= rs_id5;
            r_e_rt    <= rt_id5;
            if (w_dv && !w_stall) begin
                r_e_valid <= 1'b1;
                r_e_wreg  <= wreg_id;
                r_e_load  <= load_id;
            end else begin
                r_e_valid <= 1'b0;
                r_e_wreg  <= 1'b0;
                r_e_load  <= 1'b0;
            end

            if (!w_stall) begin
                r_d_bubble <= w_flush_d;
            end
        end
    end

    // Saturating performance counters: never wrap past all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_d && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a cycle-by-cycle vector table with
// hand-computed expectations, then sequences for asynchronous reset during a
// stall and for counter saturation (narrow counters keep that short).
module tb_hazard_controller;

    localparam int CNT_W = 3;
    localparam int NV    = 25;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       rs_id5;
    logic [4:0]       rt_id5;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic             branch_id;
    logic             zero_id;
    logic             wreg_id;
    logic             load_id;
    logic [4:0]       dst_id5;
    logic             stall_f_o;
    logic             stall_d_o;
    logic             flush_d_o;
    logic             flush_e_o;
    logic             forward_rd1_od;
    logic             forward_rd2_od;
    logic [1:0]       forward_a_oe2;
    logic [1:0]       forward_b_oe2;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int errors;
    int checks;

    // fl = {uses_rs, uses_rt, branch, zero, wreg, load}
    // eo = {stall, flush_d, forward_rd1, forward_rd2}
    typedef struct {
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [5:0]       fl;
        logic [4:0]       dst;
        logic [3:0]       eo;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } vec_t;

    vec_t tbl[NV];
    vec_t zero_v;

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs_id5         (rs_id5),
        .rt_id5         (rt_id5),
        .uses_rs_id     (uses_rs_id),
        .uses_rt_id     (uses_rt_id),
        .branch_id      (branch_id),
        .zero_id        (zero_id),
        .wreg_id        (wreg_id),
        .load_id        (load_id),
        .dst_id5        (dst_id5),
        .stall_f_o      (stall_f_o),
        .stall_d_o      (stall_d_o),
        .flush_d_o      (flush_d_o),
        .flush_e_o      (flush_e_o),
        .forward_rd1_od (forward_rd1_od),
        .forward_rd2_od (forward_rd2_od),
        .forward_a_oe2  (forward_a_oe2),
        .forward_b_oe2  (forward_b_oe2),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // Clock: posedge at 5, 15, ...; inputs change and outputs are sampled near negedges
    always #5 clk_i = ~clk_i;

    function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [5:0] fl, input logic [4:0] dst,
                                 input logic [3:0] eo, input logic [1:0] fa,
                                 input logic [1:0] fb, input int sc, input int fc);
        vec_t v;
        v.rs = rs; v.rt = rt; v.fl = fl; v.dst = dst;
        v.eo = eo; v.fa = fa; v.fb = fb;
        v.sc = CNT_W'(sc); v.fc = CNT_W'(fc);
        return v;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [5:0] fl, input logic [4:0] dst);
        rs_id5     = rs;
        rt_id5     = rt;
        uses_rs_id = fl[5];
        uses_rt_id = fl[4];
        branch_id  = fl[3];
        zero_id    = fl[2];
        wreg_id    = fl[1];
        load_id    = fl[0];
        dst_id5    = dst;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " stall_f"},   32'(stall_f_o),      32'(v.eo[3]));
        check({tag, " stall_d"},   32'(stall_d_o),      32'(v.eo[3]));
        check({tag, " flush_e"},   32'(flush_e_o),      32'(v.eo[3]));
        check({tag, " flush_d"},   32'(flush_d_o),      32'(v.eo[2]));
        check({tag, " fwd_rd1"},   32'(forward_rd1_od), 32'(v.eo[1]));
        check({tag, " fwd_rd2"},   32'(forward_rd2_od), 32'(v.eo[0]));
        check({tag, " fwd_a"},     32'(forward_a_oe2),  32'(v.fa));
        check({tag, " fwd_b"},     32'(forward_b_oe2),  32'(v.fb));
        check({tag, " stall_cnt"}, 32'(stall_cnt_o),    32'(v.sc));
        check({tag, " flush_cnt"}, 32'(flush_cnt_o),    32'(v.fc));
    endtask

    // Stimulus, checking and summary
    initial begin
        errors = 0;
        checks = 0;
        zero_v = mkv(5'd0, 5'd0, 6'b0, 5'd0, 4'b0000, 2'b00, 2'b00, 0, 0);

        //              rs  rt  fl          dst  eo       fa     fb     sc fc
        tbl[0]  = mkv(2,  2,  6'b110010, 2,  4'b0000, 2'b00, 2'b00, 0, 0); // masked first cycle
        tbl[1]  = mkv(1,  2,  6'b100011, 2,  4'b0000, 2'b00, 2'b00, 0, 0); // lw $2
        tbl[2]  = mkv(2,  4,  6'b110010, 3,  4'b1000, 2'b00, 2'b00, 0, 0); // add $3,$2,$4 stalls
        tbl[3]  = mkv(2,  4,  6'b110010, 3,  4'b0000, 2'b00, 2'b00, 1, 0); // re-presented
        tbl[4]  = mkv(6,  7,  6'b110010, 2,  4'b0000, 2'b01, 2'b00, 1, 0); // add $2; E takes load via WB
        tbl[5]  = mkv(2,  2,  6'b110010, 5,  4'b0000, 2'b00, 2'b00, 1, 0); // sub $5,$2,$2
        tbl[6]  = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b10, 2'b10, 1, 0); // sub in E: both from MEM
        tbl[7]  = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b00, 2'b00, 1, 0); // only one cycle
        tbl[8]  = mkv(1,  1,  6'b110010, 2,  4'b0000, 2'b00, 2'b00, 1, 0); // add $2
        tbl[9]  = mkv(1,  2,  6'b100011, 2,  4'b0000, 2'b00, 2'b00, 1, 0); // lw $2
        tbl[10] = mkv(2,  0,  6'b110010, 6,  4'b1010, 2'b00, 2'b10, 1, 0); // add $6,$2 stalls
        tbl[11] = mkv(2,  0,  6'b110010, 6,  4'b0000, 2'b01, 2'b00, 2, 0);
        tbl[12] = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b01, 2'b00, 2, 0); // load data via WB
        tbl[13] = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b00, 2'b00, 2, 0);
        tbl[14] = mkv(1,  2,  6'b100011, 2,  4'b0000, 2'b00, 2'b00, 2, 0); // lw $2
        tbl[15] = mkv(2,  2,  6'b111100, 0,  4'b1000, 2'b00, 2'b00, 2, 0); // beq $2,$2 stall 1
        tbl[16] = mkv(2,  2,  6'b111100, 0,  4'b1000, 2'b00, 2'b00, 3, 0); // stall 2
        tbl[17] = mkv(2,  2,  6'b111100, 0,  4'b0100, 2'b01, 2'b01, 4, 0); // resolves, flushes
        tbl[18] = mkv(2,  2,  6'b110011, 2,  4'b0000, 2'b00, 2'b00, 4, 1); // flushed slot masked
        tbl[19] = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b00, 2'b00, 4, 1);
        tbl[20] = mkv(1,  1,  6'b110010, 0,  4'b0000, 2'b00, 2'b00, 4, 1); // add $0
        tbl[21] = mkv(0,  0,  6'b110010, 4,  4'b0000, 2'b00, 2'b00, 4, 1); // add $4,$0,$0
        tbl[22] = mkv(0,  0,  6'b100011, 0,  4'b0000, 2'b00, 2'b00, 4, 1); // lw $0,0($0)
        tbl[23] = mkv(0,  0,  6'b111000, 0,  4'b0000, 2'b00, 2'b00, 4, 1); // beq $0,$0 after lw $0
        tbl[24] = mkv(0,  0,  6'b000000, 0,  4'b0000, 2'b00, 2'b00, 4, 1);

        // Reset with hazard-looking inputs applied
        rst_i = 1'b1;
        drive(5'd0, 5'd0, 6'b0, 5'd0);
        repeat (2) @(negedge clk_i);
        drive(5'd2, 5'd4, 6'b110010, 5'd3);
        #1;
        check_all("in_reset", zero_v);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].fl, tbl[i].dst);
            #1;
            check_all($sformatf("v%0d", i), tbl[i]);
            @(negedge clk_i);
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(5'd1, 5'd2, 6'b100011, 5'd2);
        @(negedge clk_i);
        drive(5'd2, 5'd4, 6'b110010, 5'd3);
        #1;
        check("midstall stall_f", 32'(stall_f_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_all("rst_mid", zero_v);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_all("post_rst", zero_v);
        @(negedge clk_i);

        // Ten load-use stalls into a 3-bit counter: saturates at 7
        for (int k = 0; k < 10; k++) begin
            drive(5'd1, 5'd2, 6'b100011, 5'd2);
            @(negedge clk_i);
            drive(5'd2, 5'd4, 6'b110010, 5'd3);
            #1;
            check($sformatf("sat_stall%0d", k), 32'(stall_f_o), 32'd1);
            @(negedge clk_i);
            @(negedge clk_i);
            if (k == 2) check("stall_cnt_3", 32'(stall_cnt_o), 32'd3);
        end
        check("stall_cnt_sat", 32'(stall_cnt_o), 32'd7);

        // Ten taken-branch flushes: saturates at 7
        for (int k = 0; k < 10; k++) begin
            drive(5'd0, 5'd0, 6'b111100, 5'd0);
            #1;
            check($sformatf("sat_flush%0d", k), 32'(flush_d_o), 32'd1);
            @(negedge clk_i);
            drive(5'd0, 5'd0, 6'b000000, 5'd0);
            #1;
            check($sformatf("masked%0d", k), 32'(flush_d_o), 32'd0);
            @(negedge clk_i);
            if (k == 1) check("flush_cnt_2", 32'(flush_cnt_o), 32'd2);
        end
        check("flush_cnt_sat", 32'(flush_cnt_o), 32'd7);
        check("stall_cnt_hold", 32'(stall_cnt_o), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
